// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers CPU load/store requests after WAIT_CYCLES wait states.
// Optional build macro DATA_MEM_RESPONDER_STATS_EN adds load/store completion counters.
module data_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DATA_MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores
`endif
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      LP_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_mem [DEPTH] = '{default: '0};

  logic                w_accept;
  logic                w_rsp_hs;
  logic                w_commit;
  logic                w_c_write;
  logic [ADDR_W-1:0]   w_c_addr;
  logic [DATA_W-1:0]   w_c_wdata;
  logic                w_c_err;
  logic [IDX_W-1:0]    w_c_idx;

  assign w_accept = req_valid & req_ready;
  assign w_rsp_hs = r_rsp_valid & rsp_ready;

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next   = (LP_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
          w_commit = (LP_WAIT == 4'd0);
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next   = ST_RESP;
          w_commit = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the acceptance edge, so use the live request.
  assign w_c_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_c_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_c_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_c_err   = ({1'b0, w_c_addr} >= LP_DEPTH);
  assign w_c_idx   = w_c_addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= LP_WAIT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_c_err;
        r_rsp_rdata <= (w_c_err || w_c_write) ? '0 : r_mem[w_c_idx];
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  // Array is not reset; the write is blocked while reset is held so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_c_write && !w_c_err)
      r_mem[w_c_idx] <= w_c_wdata;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_loads  <= 16'd0;
      r_stat_stores <= 16'd0;
    end else if (w_rsp_hs && !r_rsp_err) begin
      if (r_write) r_stat_stores <= r_stat_stores + 16'd1;
      else         r_stat_loads  <= r_stat_loads + 16'd1;
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 with WAIT_CYCLES=2, instance 1 with WAIT_CYCLES=0.
// A flat memory model predicts every response; stats are checked when DATA_MEM_RESPONDER_STATS_EN is set.
module tb_data_mem_responder;

  logic             clk = 1'b0;
  logic [1:0]       reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][15:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;
`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic [1:0][15:0] stat_loads;
  logic [1:0][15:0] stat_stores;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl [2][256];
  int          exp_ld = 0;
  int          exp_st = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DATA_MEM_RESPONDER_STATS_EN
    , .stat_loads(stat_loads[0]), .stat_stores(stat_stores[0])
`endif
  );

  data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DATA_MEM_RESPONDER_STATS_EN
    , .stat_loads(stat_loads[1]), .stat_stores(stat_stores[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input int d);
    check("rst_req_ready", 32'(req_ready[d]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    check("rst_rsp_err",   32'(rsp_err[d]),   32'd0);
  endtask

  task automatic wait_ready(input int d);
    int w;
    w = 0;
    while (!req_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before", 32'(req_ready[d]), 32'd1);
  endtask

  // One full transaction; hold = cycles the response is kept waiting before rsp_ready.
  task automatic txn(input int d, input bit wr, input logic [15:0] addr,
                     input logic [31:0] wd, input int hold);
    int          lat;
    bit          e_err;
    logic [31:0] e_rd;
    e_err = (addr >= 16'd256);
    e_rd  = (e_err || wr) ? 32'd0 : mdl[d][addr[7:0]];
    wait_ready(d);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    rsp_ready[d] = (hold == 0);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = 16'($urandom);
    req_wdata[d] = $urandom;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), (d == 0) ? 32'd3 : 32'd1);
    check("rsp_rdata", rsp_rdata[d], e_rd);
    check("rsp_err", 32'(rsp_err[d]), 32'(e_err));
    if (wr && !e_err) mdl[d][addr[7:0]] = wd;
    if (d == 1 && !e_err) begin
      if (wr) exp_st++;
      else    exp_ld++;
    end
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      @(negedge clk);
      req_valid[d] = 1'b0;
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_rdata", rsp_rdata[d], e_rd);
      check("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
    check("req_ready_after", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    bit          wr;
    logic [15:0] addr;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) mdl[d][a] = 32'd0;
    reset     = 2'b11;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 2'b00;
    @(negedge clk);
    check_reset_vals(0);

    // Store then load back, error load, untouched-array load, stalled response.
    txn(0, 1'b1, 16'h0005, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 16'h0005, 32'h0, 0);
    txn(0, 1'b0, 16'h0100, 32'h0, 0);
    txn(0, 1'b0, 16'h0000, 32'h0, 0);
    txn(0, 1'b0, 16'h0005, 32'h0, 5);

    // Reset one cycle after accepting a store: the store must not land.
    wait_ready(0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 16'h0007;
    req_wdata[0] = 32'h12345678;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1 reset[0] = 1'b1;
    @(negedge clk);
    check_reset_vals(0);
    reset[0] = 1'b0;
    @(negedge clk);
    txn(0, 1'b0, 16'h0007, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(256, 65535))
                                         : 16'($urandom_range(0, 15));
      txn(0, wr, addr, $urandom, $urandom_range(0, 3));
    end

    // Zero-wait-state instance: 2 stores, 3 loads, 1 error load.
    txn(1, 1'b1, 16'h0001, 32'hA5A5_0001, 0);
    txn(1, 1'b1, 16'h0002, 32'h5A5A_0002, 1);
    txn(1, 1'b0, 16'h0001, 32'h0, 0);
    txn(1, 1'b0, 16'h0002, 32'h0, 2);
    txn(1, 1'b0, 16'h0003, 32'h0, 0);
    txn(1, 1'b0, 16'h0200, 32'h0, 0);
`ifdef DATA_MEM_RESPONDER_STATS_EN
    check("stat_loads", 32'(stat_loads[1]), 32'(exp_ld));
    check("stat_stores", 32'(stat_stores[1]), 32'(exp_st));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
